pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have the parameter RS_DEPTH, default 4, meaning the number of return-stack entries.
REQ-002 The block SHALL have the parameter INT_VEC, default 12'd1, meaning the interrupt entry address.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have the port inst, input, 19 bits: the instruction currently addressed by cur_addr, from instruction memory.
REQ-006 The block SHALL have the port cc_z, input, 1 bit: the registered zero flag from the ALU.
REQ-007 The block SHALL have the port stall, input, 1 bit: when 1, the block holds all state.
REQ-008 The block SHALL have the port irq, input, 1 bit: the external interrupt request (level, sampled).
REQ-009 The block SHALL have the port cur_addr, output, 12 bits: the registered PC driving the instruction-memory address.
REQ-010 The block SHALL have the port int_en, output, 1 bit: the interrupt-enable flag.
REQ-011 The block SHALL have the port in_isr, output, 1 bit: 1 while a handler is executing.
REQ-012 The block SHALL have the port irq_ack, output, 1 bit: a one-cycle pulse on interrupt entry.
REQ-013 The block SHALL have the port stk_err, output, 1 bit: a sticky flag for return-stack overflow/underflow or illegal reti.

Function
REQ-014 The block SHALL decode opcode inst[18:14] as follows: 11100 jmp, 11101 jsb, 10100 bz, 10101 bnz, and 11110/11111 with sub-op inst[13:12]: 11110-00 ret, 11110-01 reti, 11111-00 enai, 11111-01 disi.
REQ-015 The block SHALL treat all other encodings as sequential, with next = cur_addr+1.
REQ-016 jmp and jsb SHALL load next = inst[11:0].
REQ-017 jsb SHALL also push cur_addr+1 onto the return stack.
REQ-018 For bz taken (cc_z=1) and bnz taken (cc_z=0), the block SHALL set next = cur_addr + 1 + sign-extended inst[7:0].
REQ-019 For bz/bnz not taken, the block SHALL set next = cur_addr+1.
REQ-020 All PC arithmetic SHALL be modulo 4096; 4095+1 wraps to 0.
REQ-021 ret SHALL pop the return stack into next.
REQ-022 ret on an empty stack SHALL give next = cur_addr+1 and set stk_err.
REQ-023 jsb on a full stack SHALL overwrite the oldest entry (circular) and set stk_err.
REQ-024 enai SHALL set int_en and disi SHALL clear it, both effective from the following cycle.
REQ-025 The block SHALL latch irq=1 into an internal pending flag on any clock.
REQ-026 Pending SHALL clear only on interrupt entry.
REQ-027 Interrupt entry SHALL occur when pending & int_en & !in_isr & !stall.
REQ-028 On interrupt entry, the current instruction SHALL complete its control effect, and its computed next SHALL be saved in the 12-bit EPC register.
REQ-029 On interrupt entry, cur_addr SHALL load INT_VEC, in_isr SHALL set to 1, and irq_ack SHALL pulse for one cycle.
REQ-030 A jsb in the entry cycle SHALL still push, and EPC SHALL receive the jsb target.
REQ-031 An enai/disi in the entry cycle SHALL take effect as normal.
REQ-032 reti with in_isr=1 SHALL load next = EPC and clear in_isr.
REQ-033 reti with in_isr=0 SHALL act as sequential and set stk_err.
REQ-034 reti and a pending interrupt SHALL not re-enter in the same cycle; re-entry is evaluated from the next cycle.
REQ-035 With stall=1, cur_addr, the stack, EPC, int_en, and in_isr SHALL hold; the pending flag SHALL still latch.
REQ-036 Latency SHALL be one instruction per cycle: next becomes cur_addr at the following clock edge, and no bubbles are inserted.

Reset
REQ-037 On rst=1 the block SHALL immediately and asynchronously set cur_addr=0, int_en=0, in_isr=0, irq_ack=0, stk_err=0, pending=0, EPC=0, and stack count=0.
REQ-038 Reset mid-handler or mid-subroutine SHALL discard all return state.
REQ-039 The first fetch after reset release SHALL be address 0.

Structure
REQ-040 The opcode/sub-op constants, INT_VEC default, and 12-bit address width SHALL live in the shared cpu package used by the decoder.
REQ-041 The return stack SHALL be one sub-module, ret_stack, with push/pop/full/empty, circular overwrite, and count, parameterised by RS_DEPTH.
REQ-042 The next-PC mux and interrupt logic SHALL remain in pc_sequencer.

Verification
REQ-043 Scenario: reset release with inst=jmp 16 at address 0, then enai at 16 -> cur_addr sequence 0, 16, 17; int_en=1 from the cycle after 16.
REQ-044 Scenario: bnz -3 at address 20 with cc_z=0 -> next 18; with cc_z=1 -> next 21; bz 4 at 6 with cc_z=1 -> next 11.
REQ-045 Scenario: jsb 2 at 26, then ret at 14 -> cur_addr 2 after 26 and 27 after ret; 5 nested jsb with RS_DEPTH=4 -> stk_err=1.
REQ-046 Scenario: int_en=1 and irq pulse while executing address 18 (sequential) -> irq_ack pulse, cur_addr=1, EPC=19; reti at 1 -> cur_addr=19, in_isr=0.
REQ-047 Scenario: second irq while in_isr=1 -> no entry until after reti; entry happens one cycle after the return.
REQ-048 Scenario: assert rst while in_isr=1 at address 3 -> outputs 0 immediately, before any clock edge; pending cleared; jmp at 4095 +1 wraps to 0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions for the program-counter sequencer: address width,
// instruction opcodes and the decoder helper used by pc_sequencer.
package pc_sequencer_pkg;

    localparam int ADDR_W = 12;
    localparam int INST_W = 19;

    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t INT_VEC_DEFAULT = 12'd1;

    localparam logic [4:0] OPC_JMP     = 5'b11100;
    localparam logic [4:0] OPC_JSB     = 5'b11101;
    localparam logic [4:0] OPC_BZ      = 5'b10100;
    localparam logic [4:0] OPC_BNZ     = 5'b10101;
    localparam logic [4:0] OPC_RET_GRP = 5'b11110;
    localparam logic [4:0] OPC_INT_GRP = 5'b11111;

    localparam logic [1:0] SUB_RET  = 2'b00;
    localparam logic [1:0] SUB_RETI = 2'b01;
    localparam logic [1:0] SUB_ENAI = 2'b00;
    localparam logic [1:0] SUB_DISI = 2'b01;

    typedef enum logic [3:0] {
        OP_SEQ,
        OP_JMP,
        OP_JSB,
        OP_BZ,
        OP_BNZ,
        OP_RET,
        OP_RETI,
        OP_ENAI,
        OP_DISI
    } op_t;

    typedef enum logic {
        ST_RUN,
        ST_ISR
    } isr_state_t;

    // Unlisted encodings, including unused sub-ops of the 1111x groups, run sequentially.
    function automatic op_t decode(input logic [INST_W-1:0] inst);
        op_t op;
        op = OP_SEQ;
        case (inst[18:14])
            OPC_JMP: op = OP_JMP;
            OPC_JSB: op = OP_JSB;
            OPC_BZ:  op = OP_BZ;
            OPC_BNZ: op = OP_BNZ;
            OPC_RET_GRP: begin
                if (inst[13:12] == SUB_RET)       op = OP_RET;
                else if (inst[13:12] == SUB_RETI) op = OP_RETI;
            end
            OPC_INT_GRP: begin
                if (inst[13:12] == SUB_ENAI)      op = OP_ENAI;
                else if (inst[13:12] == SUB_DISI) op = OP_DISI;
            end
            default: op = OP_SEQ;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// so the newest RS_DEPTH return addresses are always kept.
module ret_stack
    import pc_sequencer_pkg::*;
#(
    parameter  int RS_DEPTH = 4,
    localparam int CNT_W    = $clog2(RS_DEPTH + 1),
    localparam int PTR_W    = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  addr_t            push_data,
    output addr_t            top_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    addr_t            mem [RS_DEPTH];
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RS_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_W'(RS_DEPTH - 1) : p - PTR_W'(1);
    endfunction

    // NOTE: the storage array has no reset; count=0 already marks every entry invalid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
            if (!full) count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            wr_ptr <= ptr_dec(wr_ptr);
            count  <= count - CNT_W'(1);
        end
    end

    assign full     = (count == CNT_W'(RS_DEPTH));
    assign empty    = (count == '0);
    assign top_data = mem[ptr_dec(wr_ptr)];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, return stack control and
// single-level interrupt entry/exit with an EPC save register.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int    RS_DEPTH = 4,
    parameter addr_t INT_VEC  = INT_VEC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] inst,
    input  logic              cc_z,
    input  logic              stall,
    input  logic              irq,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              int_en,
    output logic              in_isr,
    output logic              irq_ack,
    output logic              stk_err
);

    localparam int STK_CNT_W = $clog2(RS_DEPTH + 1);

    op_t                  op;
    isr_state_t           state, state_nxt;
    addr_t                pc_inc, br_target, next_pc, epc, stk_top;
    logic                 push, pop, err_evt, int_en_nxt, reti_ok;
    logic                 pending, pending_eff, take_irq;
    logic                 stk_full, stk_empty;
    logic [STK_CNT_W-1:0] stk_count;

    assign op        = decode(inst);
    assign pc_inc    = cur_addr + addr_t'(1);
    assign br_target = pc_inc + {{(ADDR_W - 8){inst[7]}}, inst[7:0]};

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        next_pc    = pc_inc;
        push       = 1'b0;
        pop        = 1'b0;
        err_evt    = 1'b0;
        int_en_nxt = int_en;
        reti_ok    = 1'b0;
        case (op)
            OP_JMP: next_pc = inst[ADDR_W-1:0];
            OP_JSB: begin
                next_pc = inst[ADDR_W-1:0];
                push    = 1'b1;
                err_evt = stk_full;
            end
            OP_BZ:  if (cc_z)  next_pc = br_target;
            OP_BNZ: if (!cc_z) next_pc = br_target;
            OP_RET: begin
                if (stk_empty) begin
                    err_evt = 1'b1;
                end else begin
                    pop     = 1'b1;
                    next_pc = stk_top;
                end
            end
            OP_RETI: begin
                if (in_isr) begin
                    reti_ok = 1'b1;
                    next_pc = epc;
                end else begin
                    err_evt = 1'b1;
                end
            end
            OP_ENAI: int_en_nxt = 1'b1;
            OP_DISI: int_en_nxt = 1'b0;
            default: ;
        endcase
    end

    ret_stack #(.RS_DEPTH(RS_DEPTH)) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push && !stall),
        .pop       (pop && !stall),
        .push_data (pc_inc),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty),
        .count     (stk_count)
    );

    // A request arriving this cycle counts as pending, so entry can happen immediately.
    assign pending_eff = pending | irq;
    assign take_irq    = pending_eff & int_en & !in_isr & !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!stall) begin
            case (state)
                ST_RUN:  if (take_irq) state_nxt = ST_ISR;
                ST_ISR:  if (reti_ok)  state_nxt = ST_RUN;
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_comb begin
        in_isr = (state == ST_ISR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr <= '0;
            epc      <= '0;
            int_en   <= 1'b0;
            pending  <= 1'b0;
            stk_err  <= 1'b0;
            irq_ack  <= 1'b0;
        end else begin
            irq_ack <= take_irq;
            pending <= pending_eff & !take_irq;
            if (!stall) begin
                int_en  <= int_en_nxt;
                stk_err <= stk_err | err_evt;
                if (take_irq) begin
                    cur_addr <= INT_VEC;
                    epc      <= next_pc;
                end else begin
                    cur_addr <= next_pc;
                end
            end
        end
    end

    // The occupancy count must agree with the full flag reported by the stack.
    assert property (@(posedge clk) disable iff (rst)
        stk_full == (stk_count == STK_CNT_W'(RS_DEPTH)));

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: the driver queues the expected
// post-edge state for each vector, an independent monitor pops and compares.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [18:0] inst = '0;
    logic        cc_z = 1'b0;
    logic        stall = 1'b0;
    logic        irq = 1'b0;
    logic [11:0] cur_addr;
    logic        int_en, in_isr, irq_ack, stk_err;

    typedef struct {
        string       name;
        logic [11:0] addr;
        logic        en;
        logic        isr;
        logic        ack;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    event async_ev;

    localparam logic [18:0] NOP = 19'd0;

    always #5 clk = ~clk;

    pc_sequencer #(.RS_DEPTH(4), .INT_VEC(12'd1)) dut (
        .clk      (clk),
        .rst      (rst),
        .inst     (inst),
        .cc_z     (cc_z),
        .stall    (stall),
        .irq      (irq),
        .cur_addr (cur_addr),
        .int_en   (int_en),
        .in_isr   (in_isr),
        .irq_ack  (irq_ack),
        .stk_err  (stk_err)
    );

    function automatic logic [18:0] enc(input logic [4:0] opc, input logic [1:0] sub,
                                        input logic [11:0] f);
        return {opc, sub, f};
    endfunction

    task automatic expect_state(input string name, input logic [11:0] a, input logic en,
                                input logic isr, input logic ack, input logic err);
        exp_t e;
        e.name = name;
        e.addr = a;
        e.en   = en;
        e.isr  = isr;
        e.ack  = ack;
        e.err  = err;
        sb_q.push_back(e);
    endtask

    // Called at a falling edge: drive one cycle of inputs and queue the state after the next rising edge.
    task automatic step(input string name, input logic [18:0] i, input logic z, input logic rq,
                        input logic st, input logic [11:0] a, input logic en, input logic isr,
                        input logic ack, input logic err);
        inst  = i;
        cc_z  = z;
        irq   = rq;
        stall = st;
        expect_state(name, a, en, isr, ack, err);
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle and checks outputs before any clock edge occurs.
    task automatic do_reset(input string name);
        #1;
        rst   = 1'b1;
        inst  = NOP;
        irq   = 1'b0;
        stall = 1'b0;
        cc_z  = 1'b0;
        expect_state(name, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        ->async_ev;
        #2;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk or async_ev);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                vectors++;
                if ({cur_addr, int_en, in_isr, irq_ack, stk_err} !==
                    {mon_e.addr, mon_e.en, mon_e.isr, mon_e.ack, mon_e.err}) begin
                    miscompares++;
                    $display("FAIL %s: got addr=%0d en=%b isr=%b ack=%b err=%b, want addr=%0d en=%b isr=%b ack=%b err=%b",
                             mon_e.name, cur_addr, int_en, in_isr, irq_ack, stk_err,
                             mon_e.addr, mon_e.en, mon_e.isr, mon_e.ack, mon_e.err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors still queued", sb_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        do_reset("reset_state");
        //        name              inst                                z  irq stl addr  en isr ack err
        step("jmp16",          enc(OPC_JMP, 2'b00, 12'd16),        0, 0, 0, 12'd16,  0, 0, 0, 0);
        step("enai",           enc(OPC_INT_GRP, SUB_ENAI, 12'd0),  0, 0, 0, 12'd17,  1, 0, 0, 0);
        step("seq17",          NOP,                                0, 0, 0, 12'd18,  1, 0, 0, 0);
        step("irq_entry",      NOP,                                0, 1, 0, 12'd1,   1, 1, 1, 0);
        step("isr_seq",        NOP,                                0, 0, 0, 12'd2,   1, 1, 0, 0);
        step("irq_in_isr",     NOP,                                0, 1, 0, 12'd3,   1, 1, 0, 0);
        step("reti_to_epc",    enc(OPC_RET_GRP, SUB_RETI, 12'd0),  0, 0, 0, 12'd19,  1, 0, 0, 0);
        step("reentry",        NOP,                                0, 0, 0, 12'd1,   1, 1, 1, 0);
        step("reti_second",    enc(OPC_RET_GRP, SUB_RETI, 12'd0),  0, 0, 0, 12'd20,  1, 0, 0, 0);
        step("bnz_taken",      enc(OPC_BNZ, 2'b00, 12'h0FD),       0, 0, 0, 12'd18,  1, 0, 0, 0);
        step("jmp20",          enc(OPC_JMP, 2'b00, 12'd20),        0, 0, 0, 12'd20,  1, 0, 0, 0);
        step("bnz_not_taken",  enc(OPC_BNZ, 2'b00, 12'h0FD),       1, 0, 0, 12'd21,  1, 0, 0, 0);
        step("jmp6",           enc(OPC_JMP, 2'b00, 12'd6),         0, 0, 0, 12'd6,   1, 0, 0, 0);
        step("bz_taken",       enc(OPC_BZ, 2'b00, 12'd4),          1, 0, 0, 12'd11,  1, 0, 0, 0);
        step("bz_not_taken",   enc(OPC_BZ, 2'b00, 12'd4),          0, 0, 0, 12'd12,  1, 0, 0, 0);
        step("jmp26",          enc(OPC_JMP, 2'b00, 12'd26),        0, 0, 0, 12'd26,  1, 0, 0, 0);
        step("jsb2",           enc(OPC_JSB, 2'b00, 12'd2),         0, 0, 0, 12'd2,   1, 0, 0, 0);
        step("jmp14",          enc(OPC_JMP, 2'b00, 12'd14),        0, 0, 0, 12'd14,  1, 0, 0, 0);
        step("ret27",          enc(OPC_RET_GRP, SUB_RET, 12'd0),   0, 0, 0, 12'd27,  1, 0, 0, 0);
        step("jsb_n1",         enc(OPC_JSB, 2'b00, 12'd100),       0, 0, 0, 12'd100, 1, 0, 0, 0);
        step("jsb_n2",         enc(OPC_JSB, 2'b00, 12'd200),       0, 0, 0, 12'd200, 1, 0, 0, 0);
        step("jsb_n3",         enc(OPC_JSB, 2'b00, 12'd300),       0, 0, 0, 12'd300, 1, 0, 0, 0);
        step("jsb_n4_full",    enc(OPC_JSB, 2'b00, 12'd400),       0, 0, 0, 12'd400, 1, 0, 0, 0);
        step("jsb_n5_ovf",     enc(OPC_JSB, 2'b00, 12'd500),       0, 0, 0, 12'd500, 1, 0, 0, 1);
        step("ret_401",        enc(OPC_RET_GRP, SUB_RET, 12'd0),   0, 0, 0, 12'd401, 1, 0, 0, 1);
        step("ret_301",        enc(OPC_RET_GRP, SUB_RET, 12'd0),   0, 0, 0, 12'd301, 1, 0, 0, 1);
        step("ret_201",        enc(OPC_RET_GRP, SUB_RET, 12'd0),   0, 0, 0, 12'd201, 1, 0, 0, 1);
        step("ret_101",        enc(OPC_RET_GRP, SUB_RET, 12'd0),   0, 0, 0, 12'd101, 1, 0, 0, 1);
        step("ret_oldest_gone",enc(OPC_RET_GRP, SUB_RET, 12'd0),   0, 0, 0, 12'd102, 1, 0, 0, 1);
        step("stall_hold",     enc(OPC_JMP, 2'b00, 12'd7),         0, 1, 1, 12'd102, 1, 0, 0, 1);
        step("pend_entry",     NOP,                                0, 0, 0, 12'd1,   1, 1, 1, 1);
        step("disi_in_isr",    enc(OPC_INT_GRP, SUB_DISI, 12'd0),  0, 0, 0, 12'd2,   0, 1, 0, 1);
        step("reti_103",       enc(OPC_RET_GRP, SUB_RETI, 12'd0),  0, 0, 0, 12'd103, 0, 0, 0, 1);
        step("enai_again",     enc(OPC_INT_GRP, SUB_ENAI, 12'd0),  0, 0, 0, 12'd104, 1, 0, 0, 1);
        step("jsb_entry",      enc(OPC_JSB, 2'b00, 12'd50),        0, 1, 0, 12'd1,   1, 1, 1, 1);
        step("reti_jsb_tgt",   enc(OPC_RET_GRP, SUB_RETI, 12'd0),  0, 0, 0, 12'd50,  1, 0, 0, 1);
        step("ret_entry_push", enc(OPC_RET_GRP, SUB_RET, 12'd0),   0, 0, 0, 12'd105, 1, 0, 0, 1);
        step("entry_again",    NOP,                                0, 1, 0, 12'd1,   1, 1, 1, 1);
        step("isr_jmp3",       enc(OPC_JMP, 2'b00, 12'd3),         0, 0, 0, 12'd3,   1, 1, 0, 1);
        step("irq_pend_isr",   NOP,                                0, 1, 0, 12'd4,   1, 1, 0, 1);
        do_reset("async_rst_isr");
        step("enai_post_rst",  enc(OPC_INT_GRP, SUB_ENAI, 12'd0),  0, 0, 0, 12'd1,   1, 0, 0, 0);
        step("no_stale_pend",  NOP,                                0, 0, 0, 12'd2,   1, 0, 0, 0);
        step("jmp4095",        enc(OPC_JMP, 2'b00, 12'd4095),      0, 0, 0, 12'd4095,1, 0, 0, 0);
        step("wrap_inc",       NOP,                                0, 0, 0, 12'd0,   1, 0, 0, 0);
        step("bnz_back_wrap",  enc(OPC_BNZ, 2'b00, 12'h0FF),       0, 0, 0, 12'd0,   1, 0, 0, 0);
        step("ret_empty",      enc(OPC_RET_GRP, SUB_RET, 12'd0),   0, 0, 0, 12'd1,   1, 0, 0, 1);
        do_reset("rst_clr_err");
        step("reti_no_isr",    enc(OPC_RET_GRP, SUB_RETI, 12'd0),  0, 0, 0, 12'd1,   0, 0, 0, 1);
        do_reset("rst_again");
        step("bad_subop",      enc(OPC_RET_GRP, 2'b10, 12'd0),     0, 0, 0, 12'd1,   0, 0, 0, 0);
        step("disi_seq",       enc(OPC_INT_GRP, SUB_DISI, 12'd0),  0, 0, 0, 12'd2,   0, 0, 0, 0);

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never compared, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
